// File: rtl/uc_pkg.sv
// Shared constants for the microcoded sequencer: T-state and opcode names
// plus the sequencer FSM state encoding.
package uc_pkg;

  localparam logic [3:0] T0 = 4'h0, T1 = 4'h1, T2 = 4'h2, T3 = 4'h3;
  localparam logic [3:0] T4 = 4'h4, T5 = 4'h5, T6 = 4'h6, T7 = 4'h7;
  localparam logic [3:0] T8 = 4'h8, T9 = 4'h9, TA = 4'hA, TB = 4'hB;
  localparam logic [3:0] TC = 4'hC, TD = 4'hD, TE = 4'hE, TF = 4'hF;

  localparam logic [3:0] Q0 = 4'h0, Q1 = 4'h1, Q2 = 4'h2, Q3 = 4'h3;
  localparam logic [3:0] Q4 = 4'h4, Q5 = 4'h5, Q6 = 4'h6, Q7 = 4'h7;
  localparam logic [3:0] Q8 = 4'h8, Q9 = 4'h9, QA = 4'hA, QB = 4'hB;
  localparam logic [3:0] QC = 4'hC, QD = 4'hD, QE = 4'hE, QF = 4'hF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } seq_state_e;

endpackage

// File: rtl/uc_tcount.sv
// T-state counter: clears on request, wraps at TMAX and flags the wrap as a
// sticky overrun, and holds whenever en is low (halted or wait-stalled).
module uc_tcount
  import uc_pkg::*;
#(
  parameter int unsigned     TW   = 4,
  parameter logic [TW-1:0]   TMAX = TW'(4'hC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [TW-1:0] t,
  output logic          boundary,
  output logic          ovr
);

  logic [TW-1:0] t_q, t_d;
  logic          ovr_q, ovr_d;
  logic          at_max;

  assign at_max   = (t_q == TMAX);
  assign boundary = en && (clr || at_max);

  // An explicit clear wins over the wrap, so a clear at TMAX is not an overrun.
  always_comb begin
    t_d   = t_q;
    ovr_d = ovr_q;
    if (en) begin
      if (clr || at_max) t_d = '0;
      else               t_d = t_q + TW'(1);
      if (!clr && at_max) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q   <= TW'(T0);
      ovr_q <= 1'b0;
    end else begin
      t_q   <= t_d;
      ovr_q <= ovr_d;
    end
  end

  assign t   = t_q;
  assign ovr = ovr_q;

endmodule

// File: rtl/uc_sequencer.sv
// Microcode sequencer: T-state counter, instruction register, condition-code
// register and RUN/HALTED FSM. Define SEQ_WAIT_EN to let WAIT stall RUN cycles.
module uc_sequencer
  import uc_pkg::*;
#(
  parameter int unsigned   TW   = 4,
  parameter int unsigned   OPW  = 4,
  parameter logic [TW-1:0] TMAX = TW'(4'hC)
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic [7:0]     MBR,
  input  logic           X0,
  input  logic           X14,
  input  logic           X18,
  input  logic           ALU_C,
  input  logic           ALU_Z,
  input  logic           HALT_REQ,
  input  logic           WAIT,
  output logic [TW-1:0]  T,
  output logic [OPW-1:0] Q,
  output logic           C,
  output logic           Z,
  output logic           HALT_ACK,
  output logic           OVR
);

  logic freeze;
`ifdef SEQ_WAIT_EN
  assign freeze = WAIT;
`else
  logic unused_wait;
  assign unused_wait = WAIT;
  assign freeze      = 1'b0;
`endif

  seq_state_e     state_q, state_d;
  logic [OPW-1:0] ir_q, ir_d;
  logic           c_q, c_d, z_q, z_d;
  logic           ack_q, ack_d;
  logic           run_en;
  logic           boundary;

  assign run_en = (state_q == ST_RUN) && !freeze;

  uc_tcount #(
    .TW   (TW),
    .TMAX (TMAX)
  ) u_tcount (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .en       (run_en),
    .clr      (X14),
    .t        (T),
    .boundary (boundary),
    .ovr      (OVR)
  );

  // Halt is only taken at an instruction boundary, i.e. when T is being cleared.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    c_d     = c_q;
    z_d     = z_q;
    ack_d   = ack_q;
    if (run_en) begin
      if (X0) ir_d = OPW'(MBR[7:4]);
      if (X18) begin
        c_d = ALU_C;
        z_d = ALU_Z;
      end
      if (boundary && HALT_REQ) begin
        state_d = ST_HALTED;
        ack_d   = 1'b1;
      end
    end else if (state_q == ST_HALTED && !HALT_REQ) begin
      state_d = ST_RUN;
      ack_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_RUN;
      ir_q    <= OPW'(Q0);
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
    end
  end

  assign Q        = ir_q;
  assign C        = c_q;
  assign Z        = z_q;
  assign HALT_ACK = ack_q;

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed table-driven bench for uc_sequencer, plus hand sequences for
// asynchronous reset and (with SEQ_WAIT_EN) wait-state stalls.
module tb_uc_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] MBR;
  logic       X0, X14, X18, ALU_C, ALU_Z, HALT_REQ, WAIT;
  logic [3:0] T, Q;
  logic       C, Z, HALT_ACK, OVR;

  uc_sequencer #(.TW(4), .OPW(4), .TMAX(4'hC)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .MBR      (MBR),
    .X0       (X0),
    .X14      (X14),
    .X18      (X18),
    .ALU_C    (ALU_C),
    .ALU_Z    (ALU_Z),
    .HALT_REQ (HALT_REQ),
    .WAIT     (WAIT),
    .T        (T),
    .Q        (Q),
    .C        (C),
    .Z        (Z),
    .HALT_ACK (HALT_ACK),
    .OVR      (OVR)
  );

  always #5 CLK = ~CLK;

`ifdef SEQ_WAIT_EN
  localparam logic WN = 1'b0;
`else
  localparam logic WN = 1'b1;
`endif

  typedef struct {
    logic       x0, x14, x18;
    logic [7:0] mbr;
    logic       ac, az, hr, wt;
    logic [3:0] et, eq;
    logic       ec, ez, eack, eovr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic x0, x14, x18, input logic [7:0] mbr,
                     input logic ac, az, hr, wt,
                     input logic [3:0] et, eq, input logic ec, ez, eack, eovr);
    vec_t v;
    v.x0 = x0; v.x14 = x14; v.x18 = x18; v.mbr = mbr;
    v.ac = ac; v.az = az; v.hr = hr; v.wt = wt;
    v.et = et; v.eq = eq; v.ec = ec; v.ez = ez; v.eack = eack; v.eovr = eovr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [3:0] et, eq,
                           input logic ec, ez, eack, eovr);
    check({tag, ".T"},        idx, {4'h0, T},        {4'h0, et});
    check({tag, ".Q"},        idx, {4'h0, Q},        {4'h0, eq});
    check({tag, ".C"},        idx, {7'h0, C},        {7'h0, ec});
    check({tag, ".Z"},        idx, {7'h0, Z},        {7'h0, ez});
    check({tag, ".HALT_ACK"}, idx, {7'h0, HALT_ACK}, {7'h0, eack});
    check({tag, ".OVR"},      idx, {7'h0, OVR},      {7'h0, eovr});
  endtask

  task automatic drive(input logic x0, x14, x18, input logic [7:0] mbr,
                       input logic ac, az, hr, wt);
    X0 = x0; X14 = x14; X18 = x18; MBR = mbr;
    ALU_C = ac; ALU_Z = az; HALT_REQ = hr; WAIT = wt;
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RESET_N = 1'b0;
    drive(0, 0, 0, 8'h00, 0, 0, 0, 0);

    // Segment 1: count, clear at T=6, IR/CCR loads, combined strobes.
    for (int i = 1; i <= 6; i++) add(0, 0, 0, 8'h00, 0, 0, 0, (i == 2) ? WN : 1'b0, 4'(i), 4'h0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 0, 0,  4'h0, 4'h0, 0, 0, 0, 0);
    add(1, 0, 0, 8'hA5, 0, 0, 0, WN, 4'h1, 4'hA, 0, 0, 0, 0);
    add(0, 0, 0, 8'h3C, 0, 0, 0, 0,  4'h2, 4'hA, 0, 0, 0, 0);
    add(0, 0, 1, 8'h3C, 1, 0, 0, 0,  4'h3, 4'hA, 1, 0, 0, 0);
    add(0, 0, 0, 8'h3C, 0, 1, 0, 0,  4'h4, 4'hA, 1, 0, 0, 0);
    add(1, 1, 1, 8'h5A, 0, 1, 0, 0,  4'h0, 4'h5, 0, 1, 0, 0);
    // Segment 2: run to TMAX and clear exactly there (no overrun).
    for (int i = 1; i <= 12; i++) add(0, 0, 0, 8'h00, 0, 0, 0, 0, 4'(i), 4'h5, 0, 1, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 0, 0,  4'h0, 4'h5, 0, 1, 0, 0);
    // Segment 3: halt request at T=3, boundary at T=5, strobes ignored while halted.
    for (int i = 1; i <= 3; i++) add(0, 0, 0, 8'h00, 0, 0, 0, 0, 4'(i), 4'h5, 0, 1, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 1, 0,  4'h4, 4'h5, 0, 1, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 1, 0,  4'h5, 4'h5, 0, 1, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0,  4'h0, 4'h5, 0, 1, 1, 0);
    add(1, 1, 1, 8'hF0, 1, 0, 1, WN, 4'h0, 4'h5, 0, 1, 1, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 0,  4'h0, 4'h5, 0, 1, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 0,  4'h1, 4'h5, 0, 1, 0, 0);
    // Segment 4: halt request withdrawn before the boundary.
    add(0, 0, 0, 8'h00, 0, 0, 1, 0,  4'h2, 4'h5, 0, 1, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 0,  4'h3, 4'h5, 0, 1, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 0, 0,  4'h0, 4'h5, 0, 1, 0, 0);
    // Segment 5: free-run overrun, sticky OVR, then halt on an overrun wrap.
    for (int i = 1; i <= 12; i++) add(0, 0, 0, 8'h00, 0, 0, 0, 0, 4'(i), 4'h5, 0, 1, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 0,  4'h0, 4'h5, 0, 1, 0, 1);
    for (int i = 1; i <= 12; i++) add(0, 0, 0, 8'h00, 0, 0, 0, 0, 4'(i), 4'h5, 0, 1, 0, 1);
    add(0, 0, 0, 8'h00, 0, 0, 1, 0,  4'h0, 4'h5, 0, 1, 1, 1);
    add(0, 0, 0, 8'h00, 0, 0, 1, 0,  4'h0, 4'h5, 0, 1, 1, 1);
    add(0, 0, 0, 8'h00, 0, 0, 0, 0,  4'h0, 4'h5, 0, 1, 0, 1);
    add(0, 0, 0, 8'h00, 0, 0, 0, 0,  4'h1, 4'h5, 0, 1, 0, 1);

    repeat (2) @(negedge CLK);
    check_all("reset", 0, 4'h0, 4'h0, 0, 0, 0, 0);
    RESET_N = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].x0, vecs[i].x14, vecs[i].x18, vecs[i].mbr,
            vecs[i].ac, vecs[i].az, vecs[i].hr, vecs[i].wt);
      tick();
      check_all("vec", i, vecs[i].et, vecs[i].eq, vecs[i].ec, vecs[i].ez, vecs[i].eack, vecs[i].eovr);
    end

    // Asynchronous reset mid-instruction, away from any clock edge.
    drive(0, 0, 0, 8'h00, 0, 0, 0, 0);
    tick(); tick();
    check_all("pre_reset", 0, 4'h3, 4'h5, 0, 1, 0, 1);
    #2 RESET_N = 1'b0;
    #1 check_all("async_reset", 0, 4'h0, 4'h0, 0, 0, 0, 0);
    tick();
    check_all("reset_hold", 0, 4'h0, 4'h0, 0, 0, 0, 0);
    RESET_N = 1'b1;
    tick();
    check_all("post_reset", 0, 4'h1, 4'h0, 0, 0, 0, 0);

`ifdef SEQ_WAIT_EN
    tick(); tick(); tick();
    check_all("wait_pre", 0, 4'h4, 4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 8'hE1, 1, 1, 0, 1);
      tick();
      check_all("wait_hold", i, 4'h4, 4'h0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 8'h00, 0, 0, 0, 0);
    tick();
    check_all("wait_release", 0, 4'h5, 4'h0, 0, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_sequencer.md
UC_SEQUENCER -- requirements
Module: uc_sequencer

Interface
REQ-001 SHALL have parameter TW, default 4: width of T-state counter.
REQ-002 SHALL have parameter OPW, default 4: width of opcode Q.
REQ-003 SHALL have parameter TMAX, default 4'hC: last legal T-state; reaching it without clear is an overrun.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port RESET_N  input  1  asynchronous active-low reset.
REQ-006 SHALL have port MBR  input  8  memory buffer register contents; opcode = MBR[7:4].
REQ-007 SHALL have port X0  input  1  IR<=MBR load strobe from control unit.
REQ-008 SHALL have port X14  input  1  T<=0 clear strobe from control unit.
REQ-009 SHALL have port X18  input  1  CCR<=flags load strobe from control unit.
REQ-010 SHALL have port ALU_C, ALU_Z  input  1 each  ALU carry and zero flags.
REQ-011 SHALL have port HALT_REQ  input  1  level request to halt at instruction boundary.
REQ-012 SHALL have port WAIT  input  1  memory wait-state (used only with SEQ_WAIT_EN).
REQ-013 SHALL have port T  output  TW  current T-state to control unit.
REQ-014 SHALL have port Q  output  OPW  current opcode (IR) to control unit.
REQ-015 SHALL have port C, Z  output  1 each  latched condition flags (CCR).
REQ-016 SHALL have port HALT_ACK  output  1  high while in HALTED state.
REQ-017 SHALL have port OVR  output  1  sticky T-overrun error flag.

Function
REQ-018 SHALL implement FSM states RUN and HALTED; reset state RUN.
REQ-019 In RUN, per cycle: X14=1 -> T<=0; else T==TMAX -> T<=0 and OVR<=1; else T<=T+1.
REQ-020 X14 SHALL take priority over overrun detection when both apply in the same cycle (OVR not set).
REQ-021 X0=1 SHALL load Q<=MBR[7:4] at that edge; new Q visible the following cycle (1-cycle latency).
REQ-022 X18=1 SHALL load C<=ALU_C, Z<=ALU_Z at that edge; otherwise C, Z hold.
REQ-023 X0 and X18 asserted with X14 in the same cycle SHALL all take effect.
REQ-024 RUN->HALTED when T is being cleared to 0 (X14=1 or overrun wrap) and HALT_REQ=1 in that cycle.
REQ-025 In HALTED: T held at 0, Q, C, Z held, X0/X14/X18 ignored, HALT_ACK=1.
REQ-026 HALTED->RUN on first cycle with HALT_REQ=0; T advances from 0 to 1 on the next edge after exit.
REQ-027 HALT_REQ deasserted before an instruction boundary SHALL cause no halt.
REQ-028 OVR SHALL remain 1 until reset; further overruns have no additional effect.

Reset
REQ-029 RESET_N=0 SHALL immediately force T=0, Q=0, C=0, Z=0, OVR=0, HALT_ACK=0, state RUN, regardless of CLK.
REQ-030 Reset asserted mid-instruction SHALL abandon it; first post-reset edge takes T 0->1 (fetch restart).

Configuration
REQ-031 With macro SEQ_WAIT_EN defined, WAIT=1 in RUN SHALL freeze T, Q, C, Z, OVR and FSM state for that cycle (strobes ignored); WAIT ignored in HALTED.
REQ-032 Without SEQ_WAIT_EN, WAIT SHALL be unused and have no effect on any output.

Structure
REQ-033 T-state constants T0..TF, opcode constants Q0..QF and FSM state encoding SHALL live in shared package uc_pkg.
REQ-034 T counter with clear/overrun/freeze SHALL be sub-module uc_tcount; IR, CCR and FSM stay in uc_sequencer.

Verification
REQ-035 Reset then 13 free-running cycles, no X14 -> T counts 0..C, wraps to 0, OVR=1 from the wrap edge.
REQ-036 X14 pulsed at T=6 -> T=0 next cycle, OVR stays 0; X14 at T=TMAX -> T=0, OVR=0.
REQ-037 MBR=8'hA5 with X0=1 -> Q=4'hA next cycle; MBR changes with X0=0 -> Q stays 4'hA.
REQ-038 ALU_C=1, ALU_Z=0, X18=1 -> C=1, Z=0; X18=0 with ALU_Z=1 -> Z stays 0.
REQ-039 HALT_REQ=1 at T=3, X14 at T=5 -> HALT_ACK=1, T=0 held; HALT_REQ=0 -> HALT_ACK=0, T=1 next edge.
REQ-040 SEQ_WAIT_EN build: WAIT=1 for 3 cycles at T=4 with X0=1 -> T stays 4, Q unchanged; WAIT=0 -> T=5.
